// File: rtl/ctrl_decode_queue.sv
// ctrl_decode_queue: registered RV32I control decode feeding a DEPTH-entry
// FIFO. Instruction words enter through a valid/ready handshake, are decoded
// combinationally on push, and leave through a second valid/ready handshake.
// The rv32i_types package carries the control-word type shared with the
// execute stage.

package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [1:0] {
        pcmux_pc_plus4 = 2'b00,
        pcmux_alu_out  = 2'b01,
        pcmux_alu_mod2 = 2'b10
    } pcmux_sel_t;

    typedef enum logic {
        cmpmux_rs2_out = 1'b0,
        cmpmux_i_imm   = 1'b1
    } cmpmux_sel_t;

    typedef enum logic {
        alumux1_rs1_out = 1'b0,
        alumux1_pc_out  = 1'b1
    } alumux1_sel_t;

    typedef enum logic [2:0] {
        alumux2_i_imm   = 3'b000,
        alumux2_u_imm   = 3'b001,
        alumux2_b_imm   = 3'b010,
        alumux2_s_imm   = 3'b011,
        alumux2_j_imm   = 3'b100,
        alumux2_rs2_out = 3'b101
    } alumux2_sel_t;

    typedef enum logic [3:0] {
        regfilemux_alu_out  = 4'b0000,
        regfilemux_br_en    = 4'b0001,
        regfilemux_u_imm    = 4'b0010,
        regfilemux_lw       = 4'b0011,
        regfilemux_pc_plus4 = 4'b0100,
        regfilemux_lb       = 4'b0101,
        regfilemux_lbu      = 4'b0110,
        regfilemux_lh       = 4'b0111,
        regfilemux_lhu      = 4'b1000
    } regfilemux_sel_t;

    typedef struct packed {
        rv32i_opcode     opcode;
        alu_ops          aluop;
        branch_funct3_t  cmpop;
        pcmux_sel_t      pcmux_sel;
        cmpmux_sel_t     cmpmux_sel;
        alumux1_sel_t    alumux1_sel;
        alumux2_sel_t    alumux2_sel;
        regfilemux_sel_t regfilemux_sel;
        logic            mem_read;
        logic            mem_write;
        logic            regfile_load;
        logic [3:0]      mem_byte_enable;
    } rv32i_control_word;

endpackage

module ctrl_decode_queue
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter bit          EN_MEXT = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [31:0]              in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output rv32i_control_word        out_ctrl,
    output logic [31:0]              out_pc,
    output logic [4:0]               out_rd,
    output logic                     out_illegal,
    output logic                     out_muldiv,
    output logic [2:0]               out_muldiv_op,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;

    typedef struct packed {
        rv32i_control_word ctrl;
        logic [31:0]       pc;
        logic [4:0]        rd;
        logic              illegal;
        logic              muldiv;
        logic [2:0]        muldiv_op;
    } entry_t;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    rv32i_control_word dec_ctrl;
    logic              dec_illegal;
    logic              dec_muldiv;
    entry_t            dec_entry;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    // Combinational decode of the incoming word into a control word and flags
    always_comb begin
        dec_ctrl                 = '0;
        dec_ctrl.opcode          = rv32i_opcode'(opcode);
        dec_ctrl.aluop           = alu_ops'(funct3);
        dec_ctrl.cmpop           = branch_funct3_t'(funct3);
        dec_ctrl.pcmux_sel       = pcmux_pc_plus4;
        dec_ctrl.cmpmux_sel      = cmpmux_rs2_out;
        dec_ctrl.alumux1_sel     = alumux1_rs1_out;
        dec_ctrl.alumux2_sel     = alumux2_i_imm;
        dec_ctrl.regfilemux_sel  = regfilemux_alu_out;
        dec_ctrl.mem_read        = 1'b0;
        dec_ctrl.mem_write       = 1'b0;
        dec_ctrl.regfile_load    = 1'b0;
        dec_ctrl.mem_byte_enable = 4'b1111;
        dec_illegal              = 1'b0;
        dec_muldiv               = 1'b0;

        case (opcode)
            op_lui: begin
                dec_ctrl.regfilemux_sel = regfilemux_u_imm;
                dec_ctrl.regfile_load   = 1'b1;
            end
            op_auipc: begin
                dec_ctrl.alumux1_sel  = alumux1_pc_out;
                dec_ctrl.alumux2_sel  = alumux2_u_imm;
                dec_ctrl.aluop        = alu_add;
                dec_ctrl.regfile_load = 1'b1;
            end
            op_br: begin
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    dec_illegal = 1'b1;
                end
                dec_ctrl.alumux1_sel = alumux1_pc_out;
                dec_ctrl.alumux2_sel = alumux2_b_imm;
                dec_ctrl.aluop       = alu_add;
                dec_ctrl.pcmux_sel   = pcmux_alu_out;
            end
            op_jal: begin
                dec_ctrl.alumux1_sel    = alumux1_pc_out;
                dec_ctrl.alumux2_sel    = alumux2_j_imm;
                dec_ctrl.aluop          = alu_add;
                dec_ctrl.pcmux_sel      = pcmux_alu_out;
                dec_ctrl.regfilemux_sel = regfilemux_pc_plus4;
                dec_ctrl.regfile_load   = 1'b1;
            end
            op_jalr: begin
                if (funct3 != 3'b000) begin
                    dec_illegal = 1'b1;
                end
                dec_ctrl.alumux1_sel    = alumux1_rs1_out;
                dec_ctrl.alumux2_sel    = alumux2_i_imm;
                dec_ctrl.aluop          = alu_add;
                dec_ctrl.pcmux_sel      = pcmux_alu_mod2;
                dec_ctrl.regfilemux_sel = regfilemux_pc_plus4;
                dec_ctrl.regfile_load   = 1'b1;
            end
            op_load: begin
                dec_ctrl.alumux2_sel  = alumux2_i_imm;
                dec_ctrl.aluop        = alu_add;
                dec_ctrl.mem_read     = 1'b1;
                dec_ctrl.regfile_load = 1'b1;
                case (funct3)
                    3'b000:  dec_ctrl.regfilemux_sel = regfilemux_lb;
                    3'b001:  dec_ctrl.regfilemux_sel = regfilemux_lh;
                    3'b010:  dec_ctrl.regfilemux_sel = regfilemux_lw;
                    3'b100:  dec_ctrl.regfilemux_sel = regfilemux_lbu;
                    3'b101:  dec_ctrl.regfilemux_sel = regfilemux_lhu;
                    default: dec_illegal = 1'b1;
                endcase
            end
            op_store: begin
                dec_ctrl.alumux2_sel = alumux2_s_imm;
                dec_ctrl.aluop       = alu_add;
                dec_ctrl.mem_write   = 1'b1;
                case (funct3)
                    3'b000:  dec_ctrl.mem_byte_enable = 4'b0001;
                    3'b001:  dec_ctrl.mem_byte_enable = 4'b0011;
                    3'b010:  dec_ctrl.mem_byte_enable = 4'b1111;
                    default: dec_illegal = 1'b1;
                endcase
            end
            op_imm: begin
                dec_ctrl.regfile_load = 1'b1;
                case (funct3)
                    3'b010: begin
                        dec_ctrl.cmpop          = blt;
                        dec_ctrl.regfilemux_sel = regfilemux_br_en;
                        dec_ctrl.cmpmux_sel     = cmpmux_i_imm;
                    end
                    3'b011: begin
                        dec_ctrl.cmpop          = bltu;
                        dec_ctrl.regfilemux_sel = regfilemux_br_en;
                        dec_ctrl.cmpmux_sel     = cmpmux_i_imm;
                    end
                    3'b001: begin
                        if (funct7 != F7_BASE) begin
                            dec_illegal = 1'b1;
                        end
                    end
                    3'b101: begin
                        if (funct7 == F7_BASE) begin
                            dec_ctrl.aluop = alu_srl;
                        end else if (funct7 == F7_ALT) begin
                            dec_ctrl.aluop = alu_sra;
                        end else begin
                            dec_illegal = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            op_reg: begin
                dec_ctrl.alumux2_sel  = alumux2_rs2_out;
                dec_ctrl.regfile_load = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        3'b010: begin
                            dec_ctrl.cmpop          = blt;
                            dec_ctrl.regfilemux_sel = regfilemux_br_en;
                        end
                        3'b011: begin
                            dec_ctrl.cmpop          = bltu;
                            dec_ctrl.regfilemux_sel = regfilemux_br_en;
                        end
                        3'b101:  dec_ctrl.aluop = alu_srl;
                        default: ;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    case (funct3)
                        3'b000:  dec_ctrl.aluop = alu_sub;
                        3'b101:  dec_ctrl.aluop = alu_sra;
                        default: dec_illegal = 1'b1;
                    endcase
                end else if (funct7 == F7_MEXT && EN_MEXT) begin
                    dec_muldiv              = 1'b1;
                    dec_ctrl.alumux1_sel    = alumux1_rs1_out;
                    dec_ctrl.regfilemux_sel = regfilemux_alu_out;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase

        // An illegal word keeps only its opcode so the trap path can report it
        if (dec_illegal) begin
            dec_ctrl        = '0;
            dec_ctrl.opcode = rv32i_opcode'(opcode);
            dec_muldiv      = 1'b0;
        end
    end

    // Pack the decoded fields into one FIFO entry
    always_comb begin
        dec_entry           = '0;
        dec_entry.ctrl      = dec_ctrl;
        dec_entry.pc        = in_pc;
        dec_entry.rd        = in_instr[11:7];
        dec_entry.illegal   = dec_illegal;
        dec_entry.muldiv    = dec_muldiv;
        dec_entry.muldiv_op = dec_muldiv ? funct3 : 3'b000;
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    entry_t mem_q [DEPTH];
    ptr_t   wr_ptr_q, wr_ptr_d;
    ptr_t   rd_ptr_q, rd_ptr_d;
    cnt_t   count_q, count_d;
    logic   push;
    logic   pop;
    entry_t head;

    assign in_ready  = (count_q != cnt_t'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    // Next-state pointers and occupancy; flush discards any push/pop this cycle
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            if (push && !pop) begin
                count_d = count_q + cnt_t'(1);
            end else if (pop && !push) begin
                count_d = count_q - cnt_t'(1);
            end
        end
    end

    // Pointer and occupancy registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset because empty outputs are gated
    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem_q[wr_ptr_q] <= dec_entry;
        end
    end

    assign head = mem_q[rd_ptr_q];

    // Head presentation, forced to zero whenever the queue is empty
    always_comb begin
        out_ctrl      = '0;
        out_pc        = '0;
        out_rd        = '0;
        out_illegal   = 1'b0;
        out_muldiv    = 1'b0;
        out_muldiv_op = '0;
        if (out_valid) begin
            out_ctrl      = head.ctrl;
            out_pc        = head.pc;
            out_rd        = head.rd;
            out_illegal   = head.illegal;
            out_muldiv    = head.muldiv;
            out_muldiv_op = head.muldiv_op;
        end
    end

endmodule

// File: tb/tb_ctrl_decode_queue.sv
// Scoreboard bench for ctrl_decode_queue: the driver queues a hand-computed
// expected entry whenever a word is accepted; monitors pop and compare on
// every head transfer. A second instance runs with RV32M decode disabled.
module tb_ctrl_decode_queue;
    import rv32i_types::*;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        rv32i_control_word ctrl;
        logic [31:0]       pc;
        logic [4:0]        rd;
        logic              ill;
        logic              md;
        logic [2:0]        mdop;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_instr = '0;
    logic [31:0]       in_pc = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    rv32i_control_word out_ctrl;
    logic [31:0]       out_pc;
    logic [4:0]        out_rd;
    logic              out_illegal;
    logic              out_muldiv;
    logic [2:0]        out_muldiv_op;
    logic [2:0]        count;

    logic              in_valid2 = 1'b0;
    logic              in_ready2;
    logic [31:0]       in_instr2 = '0;
    logic [31:0]       in_pc2 = '0;
    logic              out_valid2;
    logic              out_ready2 = 1'b1;
    logic              flush2 = 1'b0;
    rv32i_control_word out_ctrl2;
    logic [31:0]       out_pc2;
    logic [4:0]        out_rd2;
    logic              out_illegal2;
    logic              out_muldiv2;
    logic [2:0]        out_muldiv_op2;
    logic [2:0]        count2;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];
    exp_t exp_q2[$];

    ctrl_decode_queue #(.DEPTH(DEPTH), .EN_MEXT(1'b1)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_pc(out_pc),
        .out_rd(out_rd), .out_illegal(out_illegal), .out_muldiv(out_muldiv),
        .out_muldiv_op(out_muldiv_op), .count(count)
    );

    ctrl_decode_queue #(.DEPTH(DEPTH), .EN_MEXT(1'b0)) u_dut_nom (
        .clk(clk), .rst(rst), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_instr(in_instr2), .in_pc(in_pc2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_ctrl(out_ctrl2), .out_pc(out_pc2),
        .out_rd(out_rd2), .out_illegal(out_illegal2), .out_muldiv(out_muldiv2),
        .out_muldiv_op(out_muldiv_op2), .count(count2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmp_entry(input string tag, input exp_t e, input rv32i_control_word c,
                             input logic [31:0] pc, input logic [4:0] rd, input logic ill,
                             input logic md, input logic [2:0] mdop);
        chk({tag, ".ctrl"}, 64'(c), 64'(e.ctrl));
        chk({tag, ".pc"}, 64'(pc), 64'(e.pc));
        chk({tag, ".rd_ill_md_op"}, 64'({rd, ill, md, mdop}), 64'({e.rd, e.ill, e.md, e.mdop}));
    endtask

    // Spec default control word for a given opcode/funct3
    function automatic rv32i_control_word dflt(input rv32i_opcode op, input logic [2:0] f3);
        rv32i_control_word c;
        c                 = '0;
        c.opcode          = op;
        c.aluop           = alu_ops'(f3);
        c.cmpop           = branch_funct3_t'(f3);
        c.pcmux_sel       = pcmux_pc_plus4;
        c.cmpmux_sel      = cmpmux_rs2_out;
        c.alumux1_sel     = alumux1_rs1_out;
        c.alumux2_sel     = alumux2_i_imm;
        c.regfilemux_sel  = regfilemux_alu_out;
        c.mem_byte_enable = 4'b1111;
        return c;
    endfunction

    function automatic rv32i_control_word illc(input logic [6:0] op);
        rv32i_control_word c;
        c        = '0;
        c.opcode = rv32i_opcode'(op);
        return c;
    endfunction

    function automatic exp_t mk(input rv32i_control_word c, input logic [31:0] pc,
                                input logic [4:0] rd, input logic ill, input logic md,
                                input logic [2:0] mdop);
        exp_t e;
        e.ctrl = c; e.pc = pc; e.rd = rd; e.ill = ill; e.md = md; e.mdop = mdop;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
        bit ok = 1'b0;
        in_valid = 1'b1; in_instr = instr; in_pc = pc;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk); #1;
            if (ok) break;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout: pc %h not accepted, expected acceptance", pc);
        end
        in_valid = 1'b0;
    endtask

    task automatic send2(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
        bit ok = 1'b0;
        in_valid2 = 1'b1; in_instr2 = instr; in_pc2 = pc;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready2) begin
                exp_q2.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk); #1;
            if (ok) break;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send2_timeout: pc %h not accepted, expected acceptance", pc);
        end
        in_valid2 = 1'b0;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (count == 3'd0) break;
        end
        chk({tag, ".drain_count"}, 64'(count), 64'd0);
        chk({tag, ".drain_sb"}, 64'(exp_q.size()), 64'd0);
        out_ready = 1'b0;
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, ".count"}, 64'(count), 64'd0);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, ".ctrl"}, 64'(out_ctrl), 64'd0);
        chk({tag, ".pc"}, 64'(out_pc), 64'd0);
        chk({tag, ".rd_ill_md_op"}, 64'({out_rd, out_illegal, out_muldiv, out_muldiv_op}), 64'd0);
    endtask

    // Monitor: compares the head against the scoreboard on every pop
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL pop_unexpected: got pc %h, expected no entry", out_pc);
            end else begin
                e = exp_q.pop_front();
                cmp_entry("pop", e, out_ctrl, out_pc, out_rd, out_illegal, out_muldiv, out_muldiv_op);
            end
        end
    end

    // Monitor for the instance with RV32M disabled
    always @(negedge clk) begin : mon2
        exp_t e;
        if (!rst && out_valid2 && out_ready2) begin
            if (exp_q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL pop2_unexpected: got pc %h, expected no entry", out_pc2);
            end else begin
                e = exp_q2.pop_front();
                cmp_entry("nom", e, out_ctrl2, out_pc2, out_rd2, out_illegal2, out_muldiv2, out_muldiv_op2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rv32i_control_word c;
        rv32i_control_word c_addi;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_empty("reset");

        // Basic ALU: addi x1,x0,5
        c_addi = dflt(op_imm, 3'b000);
        c_addi.regfile_load = 1'b1;
        send(32'h00500093, 32'h100, mk(c_addi, 32'h100, 5'd1, 1'b0, 1'b0, 3'b000));
        chk("basic.out_valid", 64'(out_valid), 64'd1);
        chk("basic.count", 64'(count), 64'd1);
        chk("basic.alumux2", 64'(out_ctrl.alumux2_sel), 64'(alumux2_i_imm));
        chk("basic.aluop", 64'(out_ctrl.aluop), 64'(alu_add));
        chk("basic.load", 64'(out_ctrl.regfile_load), 64'd1);
        chk("basic.rd", 64'(out_rd), 64'd1);
        chk("basic.illegal", 64'(out_illegal), 64'd0);

        // Decode variants streamed with the consumer ready
        out_ready = 1'b1;
        c = dflt(op_reg, 3'b000); c.aluop = alu_sub; c.alumux2_sel = alumux2_rs2_out; c.regfile_load = 1'b1;
        send(32'h402081B3, 32'h104, mk(c, 32'h104, 5'd3, 1'b0, 1'b0, 3'b000));
        c = dflt(op_reg, 3'b000); c.alumux2_sel = alumux2_rs2_out; c.regfile_load = 1'b1;
        send(32'h022081B3, 32'h108, mk(c, 32'h108, 5'd3, 1'b0, 1'b1, 3'b000));
        send(32'h00013083, 32'h10C, mk(illc(7'b0000011), 32'h10C, 5'd1, 1'b1, 1'b0, 3'b000));
        send(32'hFFFFFFFF, 32'h110, mk(illc(7'b1111111), 32'h110, 5'd31, 1'b1, 1'b0, 3'b000));
        c = dflt(op_load, 3'b010); c.aluop = alu_add; c.mem_read = 1'b1; c.regfile_load = 1'b1;
        c.regfilemux_sel = regfilemux_lw;
        send(32'h0000A103, 32'h114, mk(c, 32'h114, 5'd2, 1'b0, 1'b0, 3'b000));
        c = dflt(op_store, 3'b010); c.aluop = alu_add; c.alumux2_sel = alumux2_s_imm; c.mem_write = 1'b1;
        send(32'h0020A023, 32'h118, mk(c, 32'h118, 5'd0, 1'b0, 1'b0, 3'b000));
        c = dflt(op_store, 3'b001); c.aluop = alu_add; c.alumux2_sel = alumux2_s_imm; c.mem_write = 1'b1;
        c.mem_byte_enable = 4'b0011;
        send(32'h00209023, 32'h11C, mk(c, 32'h11C, 5'd0, 1'b0, 1'b0, 3'b000));
        c = dflt(op_jal, 3'b000); c.alumux1_sel = alumux1_pc_out; c.alumux2_sel = alumux2_j_imm;
        c.aluop = alu_add; c.pcmux_sel = pcmux_alu_out; c.regfilemux_sel = regfilemux_pc_plus4;
        c.regfile_load = 1'b1;
        send(32'h008000EF, 32'h120, mk(c, 32'h120, 5'd1, 1'b0, 1'b0, 3'b000));
        c = dflt(op_br, 3'b000); c.alumux1_sel = alumux1_pc_out; c.alumux2_sel = alumux2_b_imm;
        c.aluop = alu_add; c.pcmux_sel = pcmux_alu_out;
        send(32'h00208463, 32'h124, mk(c, 32'h124, 5'd8, 1'b0, 1'b0, 3'b000));
        c = dflt(op_lui, 3'b101); c.regfilemux_sel = regfilemux_u_imm; c.regfile_load = 1'b1;
        send(32'h123450B7, 32'h128, mk(c, 32'h128, 5'd1, 1'b0, 1'b0, 3'b000));
        c = dflt(op_imm, 3'b010); c.cmpop = blt; c.regfilemux_sel = regfilemux_br_en;
        c.cmpmux_sel = cmpmux_i_imm; c.regfile_load = 1'b1;
        send(32'h0050A093, 32'h12C, mk(c, 32'h12C, 5'd1, 1'b0, 1'b0, 3'b000));
        c = dflt(op_imm, 3'b101); c.aluop = alu_sra; c.regfile_load = 1'b1;
        send(32'h4020D093, 32'h130, mk(c, 32'h130, 5'd1, 1'b0, 1'b0, 3'b000));
        drain("variants");

        // Fill and order: four accepted, fifth stalls until a pop frees a slot
        for (int i = 0; i < 4; i++) begin
            send(32'h00500093, 32'h200 + 32'(4 * i), mk(c_addi, 32'h200 + 32'(4 * i), 5'd1, 1'b0, 1'b0, 3'b000));
        end
        chk("fill.count", 64'(count), 64'd4);
        chk("fill.in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h210;
        repeat (2) @(posedge clk);
        #1;
        chk("fill.stall_count", 64'(count), 64'd4);
        chk("fill.stall_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        send(32'h00500093, 32'h210, mk(c_addi, 32'h210, 5'd1, 1'b0, 1'b0, 3'b000));
        drain("fill");

        // Concurrent push/pop at count=2 across pointer wrap
        send(32'h00500093, 32'h300, mk(c_addi, 32'h300, 5'd1, 1'b0, 1'b0, 3'b000));
        send(32'h00500093, 32'h304, mk(c_addi, 32'h304, 5'd1, 1'b0, 1'b0, 3'b000));
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(32'h00500093, 32'h308 + 32'(4 * i), mk(c_addi, 32'h308 + 32'(4 * i), 5'd1, 1'b0, 1'b0, 3'b000));
            chk("pp.count", 64'(count), 64'd2);
        end
        drain("pp");

        // Flush with concurrent push and pop requests
        for (int i = 0; i < 3; i++) begin
            send(32'h00500093, 32'h400 + 32'(4 * i), mk(c_addi, 32'h400 + 32'(4 * i), 5'd1, 1'b0, 1'b0, 3'b000));
        end
        chk("flush.pre_count", 64'(count), 64'd3);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h40C; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        chk_empty("flush");
        @(posedge clk); #1;
        chk("flush.count_hold", 64'(count), 64'd0);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) begin
            send(32'h402081B3, 32'h500 + 32'(4 * i), mk(c_addi, 32'h500 + 32'(4 * i), 5'd3, 1'b0, 1'b0, 3'b000));
        end
        chk("rst.pre_count", 64'(count), 64'd3);
        rst = 1'b1; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h50C; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        exp_q.delete();
        chk_empty("rst_mid");

        // RV32M disabled: mul becomes illegal, sub stays legal
        send2(32'h022081B3, 32'h600, mk(illc(7'b0110011), 32'h600, 5'd3, 1'b1, 1'b0, 3'b000));
        c = dflt(op_reg, 3'b000); c.aluop = alu_sub; c.alumux2_sel = alumux2_rs2_out; c.regfile_load = 1'b1;
        send2(32'h402081B3, 32'h604, mk(c, 32'h604, 5'd3, 1'b0, 1'b0, 3'b000));
        repeat (3) @(posedge clk);
        #1;
        chk("nom.drain_sb", 64'(exp_q2.size()), 64'd0);
        chk("nom.count", 64'(count2), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_decode_queue.md
Name: ctrl_decode_queue

Overview:
Registered, parametrised successor to the combinational control decode. It accepts fetched instruction words with a valid/ready handshake and decodes each into an rv32i_control_word plus illegal-instruction and RV32M flags. Decoded entries are buffered in a DEPTH-entry FIFO that feeds the execute stage through a second valid/ready handshake. A flush input supports branch and jump redirects.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, at least 2.
EN_MEXT, 1, 1 = decode RV32M (op_reg with funct7 0000001) as legal; 0 = treat it as illegal.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
flush  in  1  synchronous; discards all buffered entries
in_valid  in  1  instruction word present
in_ready  out  1  queue can accept a word
in_instr  in  32  raw instruction word
in_pc  in  32  PC of in_instr
out_valid  out  1  head entry valid
out_ready  in  1  consumer takes the head entry
out_ctrl  out  rv32i_control_word  decoded control word at the head
out_pc  out  32  PC at the head
out_rd  out  5  instr[11:7] at the head
out_illegal  out  1  head instruction is illegal
out_muldiv  out  1  head instruction is RV32M
out_muldiv_op  out  3  RV32M funct3 at the head (0 otherwise)
count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: count=0, pointers=0, out_valid=0, in_ready=1. out_ctrl, out_pc, out_rd, out_illegal, out_muldiv and out_muldiv_op all read 0.
- Handshake: push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Ready and valid: in_ready = (count != DEPTH), with no combinational dependence on out_ready. out_valid = (count != 0).
- Empty outputs: when out_valid=0, all out_* data ports are forced to 0.
- Decode timing: decode is combinational on in_instr and is written into the tail entry on push. Latency is 1 cycle: a word pushed at edge N is visible at the head after edge N, if the queue was empty.
- Push and pop together: push with pop in the same cycle leaves count unchanged. This is legal at any count in 1..DEPTH-1.
- Full: when full, in_ready=0. A pop that cycle still does not permit a push. count goes DEPTH -> DEPTH-1.
- Pointers: 2-bit wrap-around for DEPTH=4; pointers wrap modulo DEPTH.
- Priority: rst > flush > push/pop.
- Flush: flush=1 empties the queue at the next edge and ignores any push or pop that cycle. out_valid=0 the following cycle. in_ready stays 1.
- Default decode values: aluop=funct3, pcmux pc_plus4, cmpmux rs2_out, alumux1 rs1_out, alumux2 i_imm, regfilemux alu_out, cmpop=funct3, mem_read=0, mem_write=0, regfile_load=0, mem_byte_enable=1111.
- lui: regfilemux u_imm, load.
- auipc: pc_out + u_imm, add, load.
- br: pc_out + b_imm, pcmux alu_out.
- jal: pc_out + j_imm, pcmux alu_out, regfilemux pc_plus4, load.
- jalr: rs1 + i_imm, pcmux alu_mod2, regfilemux pc_plus4, load.
- load: rs1 + i_imm, add, mem_read, load, regfilemux per funct3 (lb, lh, lw, lbu, lhu).
- store: rs1 + s_imm, add, mem_write, byte enable sb 0001 / sh 0011 / sw 1111.
- op_imm and op_reg: slt/sltu set cmpop blt/bltu and regfilemux br_en; cmpmux is i_imm for op_imm and rs2_out for op_reg. sr selects srl when funct7=0000000 and sra when funct7=0100000. op_reg add selects sub when funct7=0100000. op_reg sets alumux2 rs2_out. Both set load.
- RV32M (EN_MEXT=1, op_reg, funct7=0000001): muldiv=1, muldiv_op=funct3, alumux rs1/rs2, regfilemux alu_out, load.
- Illegal cases (entry gets ctrl all zero except opcode, illegal=1, muldiv=0):
  - unknown opcode
  - branch funct3 010 or 011
  - load funct3 011, 110 or 111
  - store funct3 at or above 011
  - jalr funct3 != 000
  - op_imm slli with funct7 != 0
  - op_imm sr with funct7 not in {0000000, 0100000}
  - op_reg funct7 not in {0000000, 0100000, 0000001 when EN_MEXT}
  - op_reg funct7=0100000 with funct3 other than add or sr
  - op_reg funct7=0000001 when EN_MEXT=0
- Reset mid-stream: identical to flush, applied at the next edge. Partially decoded state is discarded.

Test Plan:
- Basic ALU: reset, then push 0x00500093 (addi x1,x0,5) with out_ready=0. The cycle after the push shows out_valid=1, count=1, alumux2 i_imm, aluop add, regfile_load=1, out_rd=1, illegal=0.
- Fill and order: push 5 words back-to-back with out_ready=0. Words 1-4 are accepted, in_ready drops after the 4th, and word 5 stalls. Raise out_ready: pops occur in order with the correct out_pc sequence, and word 5 is accepted only once count<4.
- Decode variants: 0x402081B3 (sub) gives aluop sub and alumux2 rs2_out. 0x022081B3 (mul) gives muldiv=1, muldiv_op=000 with EN_MEXT=1, and illegal=1 with ctrl zero when EN_MEXT=0.
- Illegal words: 0x00013083 (load funct3 011) and 0xFFFFFFFF each give illegal=1, mem_read=0, regfile_load=0.
- Concurrent push/pop: with count=2, assert push and pop every cycle for 10 cycles. count stays 2 and the pointers wrap cleanly past DEPTH.
- Flush and reset: with count=3, assert flush together with in_valid and out_ready. Next cycle count=0, out_valid=0, nothing is pushed. Repeat with rst mid-stream and expect the same result with outputs at 0.
